cal_core: RTL and testbench

CAL_CORE -- requirements
Module: cal_core

---
 rtl/cal_core_pkg.sv | 21 ++
 rtl/q08_mul.sv | 23 ++
 rtl/cal_core.sv | 154 +++++++++++++++
 tb/tb_cal_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cal_core_pkg.sv
// Shared types and constants for the calibration row-product core.
// The CAL_CORE_ROUND_EN macro (see q08_mul) selects round-to-nearest in the Q0.8 multiply.
package cal_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int Q_WIDTH   = 8;
    localparam int ACC_WIDTH = Q_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ONE_Q = 9'd256;

    // The accumulator can only exceed 255 when it still holds exactly 1.0.
    function automatic logic [Q_WIDTH-1:0] sat_q(input logic [ACC_WIDTH-1:0] v);
        return v[ACC_WIDTH-1] ? {Q_WIDTH{1'b1}} : v[Q_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/q08_mul.sv
// 9-bit accumulator times 8-bit Q0.8 probability, rescaled back to 9 bits.
// Truncates by default; CAL_CORE_ROUND_EN adds half an LSB before the shift.
module q08_mul
    import cal_core_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [Q_WIDTH-1:0]   x,
    output logic [ACC_WIDTH-1:0] y
);

    logic [2*Q_WIDTH:0] prod;

    always_comb begin
        prod = {{Q_WIDTH{1'b0}}, acc} * {{ACC_WIDTH{1'b0}}, x};
`ifdef CAL_CORE_ROUND_EN
        prod = prod + (2*Q_WIDTH+1)'(1 << (Q_WIDTH - 1));
`else
        prod = prod;
`endif
        y = ACC_WIDTH'(prod >> Q_WIDTH);
    end

endmodule

// File: rtl/cal_core.sv
// Per-row product of alpha probabilities over the columns selected by H_row, one per symbol.
// Build option: CAL_CORE_ROUND_EN selects rounding in the q08_mul instances.
module cal_core
    import cal_core_pkg::*;
#(
    parameter  int J       = 14,
    parameter  int I       = 7,
    parameter  int A       = 2,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int I_WIDTH = $clog2(I) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [J-1:0]         H_row,
    input  logic                 H_row_tvalid,
    input  logic [J*8-1:0]       alpha_u_col,
    input  logic                 alpha_u_col_tvalid,
    input  logic                 alpha_u_col_tlast,
    output logic                 in_ready,
    output logic [A*8-1:0]       prod_out,
    output logic                 prod_tvalid,
    output logic                 prod_tlast,
    output logic [I_WIDTH-1:0]   row_idx
);

    state_e                   state, state_d;
    logic [I_WIDTH-1:0]       row_idx_q, row_idx_d;
    logic [J-1:0]             mask_q, mask_d;
    logic [J*Q_WIDTH-1:0]     buf_q [A];
    logic [J*Q_WIDTH-1:0]     buf_d [A];
    logic [A_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
    logic [J_WIDTH-1:0]       col_q, col_d;
    logic [ACC_WIDTH-1:0]     acc_q [A];
    logic [ACC_WIDTH-1:0]     acc_d [A];
    logic [ACC_WIDTH-1:0]     mul_y [A];
    logic [A*Q_WIDTH-1:0]     prod_out_q, prod_out_d;
    logic                     prod_tvalid_q, prod_tvalid_d;
    logic                     prod_tlast_q, prod_tlast_d;
    logic                     accept;

    // Buffers and mask shift right during CALC, so lane 0 / bit 0 is always column c.
    for (genvar a = 0; a < A; a++) begin : g_mul
        q08_mul u_mul (
            .acc (acc_q[a]),
            .x   (buf_q[a][Q_WIDTH-1:0]),
            .y   (mul_y[a])
        );
    end

    assign in_ready    = (state == IDLE) || (state == LOAD);
    assign accept      = in_ready & alpha_u_col_tvalid;
    assign prod_out    = prod_out_q;
    assign prod_tvalid = prod_tvalid_q;
    assign prod_tlast  = prod_tlast_q;
    assign row_idx     = row_idx_q;

    always_comb begin
        state_d       = state;
        row_idx_d     = row_idx_q;
        mask_d        = mask_q;
        beat_cnt_d    = beat_cnt_q;
        col_d         = col_q;
        prod_out_d    = prod_out_q;
        prod_tvalid_d = 1'b0;
        prod_tlast_d  = 1'b0;
        for (int a = 0; a < A; a++) begin
            buf_d[a] = buf_q[a];
            acc_d[a] = acc_q[a];
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    mask_d     = H_row_tvalid ? H_row : '0;
                    beat_cnt_d = A_WIDTH'(1);
                    for (int a = 0; a < A; a++) begin
                        buf_d[a] = (a == 0) ? alpha_u_col : '0;
                    end
                    state_d = alpha_u_col_tlast ? CALC : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (beat_cnt_q < A_WIDTH'(A)) begin
                        for (int a = 0; a < A; a++) begin
                            if (beat_cnt_q == A_WIDTH'(a)) buf_d[a] = alpha_u_col;
                        end
                        beat_cnt_d = beat_cnt_q + A_WIDTH'(1);
                    end
                    if (alpha_u_col_tlast) state_d = CALC;
                end
            end
            CALC: begin
                for (int a = 0; a < A; a++) begin
                    if (mask_q[0]) acc_d[a] = mul_y[a];
                    buf_d[a] = buf_q[a] >> Q_WIDTH;
                end
                mask_d = mask_q >> 1;
                col_d  = col_q + J_WIDTH'(1);
                if (col_q == J_WIDTH'(J - 1)) begin
                    state_d       = DONE;
                    prod_tvalid_d = 1'b1;
                    prod_tlast_d  = (row_idx_q == I_WIDTH'(I - 1));
                    for (int a = 0; a < A; a++) begin
                        prod_out_d[a*Q_WIDTH +: Q_WIDTH] = sat_q(acc_d[a]);
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                row_idx_d = (row_idx_q == I_WIDTH'(I - 1)) ? '0 : row_idx_q + I_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase

        // Every path into CALC starts a fresh product at 1.0.
        if (accept && alpha_u_col_tlast) begin
            col_d = '0;
            for (int a = 0; a < A; a++) acc_d[a] = ONE_Q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            row_idx_q     <= '0;
            mask_q        <= '0;
            beat_cnt_q    <= '0;
            col_q         <= '0;
            prod_out_q    <= '0;
            prod_tvalid_q <= 1'b0;
            prod_tlast_q  <= 1'b0;
            for (int a = 0; a < A; a++) begin
                buf_q[a] <= '0;
                acc_q[a] <= ONE_Q;
            end
        end else begin
            state         <= state_d;
            row_idx_q     <= row_idx_d;
            mask_q        <= mask_d;
            beat_cnt_q    <= beat_cnt_d;
            col_q         <= col_d;
            prod_out_q    <= prod_out_d;
            prod_tvalid_q <= prod_tvalid_d;
            prod_tlast_q  <= prod_tlast_d;
            for (int a = 0; a < A; a++) begin
                buf_q[a] <= buf_d[a];
                acc_q[a] <= acc_d[a];
            end
        end
    end

endmodule

// File: tb/tb_cal_core.sv
// Directed bench for cal_core: hand-computed row products, latency, tlast/row_idx wrap, reset abort.
// Expects sym0=0x02 for the first vector set when CAL_CORE_ROUND_EN is defined, 0x01 otherwise.
module tb_cal_core;

    localparam int J  = 14;
    localparam int I  = 7;
    localparam int A  = 2;
    localparam int IW = $clog2(I) + 1;

    localparam logic [J*8-1:0] BEAT0 = 112'h74CEB3E7BFCE161B510533F9A6FF;
    localparam logic [J*8-1:0] BEAT1 = 112'h8B324D194132E9E5AEFBCD065A01;
    localparam logic [J*8-1:0] L80   = {J{8'h80}};
    localparam logic [J-1:0]   MASK1 = 14'b01100010100011;
`ifdef CAL_CORE_ROUND_EN
    localparam logic [15:0]    S1_EXP = 16'h0002;
`else
    localparam logic [15:0]    S1_EXP = 16'h0001;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [J-1:0]    H_row = '0;
    logic            H_row_tvalid = 1'b0;
    logic [J*8-1:0]  alpha_u_col = '0;
    logic            alpha_u_col_tvalid = 1'b0;
    logic            alpha_u_col_tlast = 1'b0;
    logic            in_ready;
    logic [A*8-1:0]  prod_out;
    logic            prod_tvalid;
    logic            prod_tlast;
    logic [IW-1:0]   row_idx;

    int checks = 0;
    int errors = 0;

    cal_core #(.J(J), .I(I), .A(A)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .H_row              (H_row),
        .H_row_tvalid       (H_row_tvalid),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (alpha_u_col_tvalid),
        .alpha_u_col_tlast  (alpha_u_col_tlast),
        .in_ready           (in_ready),
        .prod_out           (prod_out),
        .prod_tvalid        (prod_tvalid),
        .prod_tlast         (prod_tlast),
        .row_idx            (row_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [J*8-1:0] d, input logic last,
                        input logic [J-1:0] h, input logic hv);
        alpha_u_col        = d;
        alpha_u_col_tlast  = last;
        H_row              = h;
        H_row_tvalid       = hv;
        alpha_u_col_tvalid = 1'b1;
        @(posedge clk);
        #1;
        alpha_u_col_tvalid = 1'b0;
        alpha_u_col_tlast  = 1'b0;
        H_row_tvalid       = 1'b0;
    endtask

    // Latency counted in cycles from the cycle the tlast beat is presented.
    task automatic wait_out(input string tag, input logic [15:0] exp_prod, input logic exp_last);
        int lat;
        lat = 1;
        while (prod_tvalid !== 1'b1 && lat < 4 * J) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(J + 1));
        chk({tag, "_prod"}, 64'(prod_out), 64'(exp_prod));
        chk({tag, "_tlast"}, 64'(prod_tlast), 64'(exp_last));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(prod_tvalid), 64'd0);
    endtask

    initial begin
        int seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(dut.state), 64'd0);
        chk("rst_prod", 64'(prod_out), 64'd0);
        chk("rst_tvalid", 64'(prod_tvalid), 64'd0);
        chk("rst_tlast", 64'(prod_tlast), 64'd0);
        chk("rst_row", 64'(row_idx), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Row 0: reference vectors.
        send(BEAT0, 1'b0, MASK1, 1'b1);
        chk("s1_load", 64'(dut.state), 64'd1);
        send(BEAT1, 1'b1, '0, 1'b0);
        chk("s1_calc", 64'(dut.state), 64'd2);
        chk("s1_ready_calc", 64'(in_ready), 64'd0);
        wait_out("s1", S1_EXP, 1'b0);
        chk("s1_row", 64'(row_idx), 64'd1);

        // Row 1: 0.5 * 0.5 on both symbols.
        send(L80, 1'b0, 14'b11, 1'b1);
        send(L80, 1'b1, '0, 1'b0);
        wait_out("s3", 16'h4040, 1'b0);

        // Row 2: empty mask saturates to 0xFF.
        send(L80, 1'b0, '0, 1'b1);
        send(L80, 1'b1, '0, 1'b0);
        wait_out("s4", 16'hFFFF, 1'b0);

        // Row 3: H_row without H_row_tvalid is treated as an empty mask.
        send(L80, 1'b0, 14'h3FFF, 1'b0);
        send(L80, 1'b1, '0, 1'b0);
        wait_out("hv0", 16'hFFFF, 1'b0);

        // Row 4: tlast on the first beat leaves slot 1 at zero.
        send(L80, 1'b1, 14'b1, 1'b1);
        wait_out("short", 16'h0080, 1'b0);

        // Row 5: a third beat is dropped.
        send(L80, 1'b0, 14'b11, 1'b1);
        send(L80, 1'b0, '0, 1'b0);
        send('0, 1'b1, '0, 1'b0);
        wait_out("extra", 16'h4040, 1'b0);
        chk("extra_row", 64'(row_idx), 64'd6);

        // Row 6 abandoned by reset during CALC.
        send(L80, 1'b0, 14'b11, 1'b1);
        send(L80, 1'b1, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_state", 64'(dut.state), 64'd0);
        chk("abort_row", 64'(row_idx), 64'd0);
        chk("abort_prod", 64'(prod_out), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < J + 4; c++) begin
            @(posedge clk);
            #1;
            if (prod_tvalid === 1'b1) seen++;
        end
        chk("abort_no_out", 64'(seen), 64'd0);

        // A full frame of I rows after reset.
        for (int k = 0; k < I; k++) begin
            chk($sformatf("s5_row%0d", k), 64'(row_idx), 64'(k));
            send(BEAT0, 1'b0, MASK1, 1'b1);
            send(BEAT1, 1'b1, '0, 1'b0);
            wait_out($sformatf("s5_%0d", k), S1_EXP, (k == I - 1));
        end
        chk("s5_wrap", 64'(row_idx), 64'd0);
        chk("s5_idle", 64'(dut.state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
